decoder_nx2n_seq: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with valid/ready input handshake and an optional autonomous scan mode. The scan mode walks a single active output across all 2^SEL_W lines at a programmable dwell rate. It replaces fixed 3-to-8 combinational decoders in the semi designs wherever a clocked, glitch-free one-hot select is needed, such as row/digit strobes or channel enables. Default parameters give the 3-to-8 case.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/dwell_counter.sv | 28 ++
 rtl/decoder_nx2n_seq.sv | 122 ++++++++++++
 tb/tb_decoder_nx2n_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
// State encoding, mode constants and the binary-to-one-hot helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Sized for the widest legal select (6 bits); callers truncate to their width.
  function automatic logic [63:0] onehot(input logic [5:0] i);
    onehot = 64'd1 << i;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Free-running 0..DWELL-1 counter; tick_out marks the last cycle of each dwell.
module dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_out
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_out = (cnt == LAST);

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input handshake.
// Optional autonomous scan mode is built when DECODER_NX2N_SCAN_EN is defined.
module decoder_nx2n_seq
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel,
  output logic                    sel_ready,
  output logic [(2**SEL_W)-1:0]   D,
  output logic                    d_valid,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int unsigned OUT_W = 2**SEL_W;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] d_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             dv_nxt;
  logic             wrap_nxt;
  logic             xfer;

  assign sel_ready = en && !rst && (state == DIRECT);
  assign xfer      = sel_valid && sel_ready;

`ifdef DECODER_NX2N_SCAN_EN
  logic tick;
  logic cnt_clr;

  // Counter restarts on scan entry so line 0 gets a full dwell.
  assign cnt_clr = (state != SCAN) || (state_nxt != SCAN);

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .tick_out (tick)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (mode == MODE_SCAN) ^ (DWELL == 0);
`endif

  always_comb begin
    state_nxt = IDLE;
    d_nxt     = D;
    idx_nxt   = idx;
    dv_nxt    = d_valid;
    wrap_nxt  = 1'b0;

    if (!en) begin
      state_nxt = IDLE;
    end
`ifdef DECODER_NX2N_SCAN_EN
    else if (mode == MODE_SCAN) begin
      state_nxt = SCAN;
    end
`endif
    else begin
      state_nxt = DIRECT;
    end

    case (state_nxt)
      DIRECT: begin
        if (state != DIRECT) begin
          d_nxt   = '0;
          idx_nxt = '0;
          dv_nxt  = 1'b0;
        end else if (xfer) begin
          d_nxt   = OUT_W'(onehot(6'(sel)));
          idx_nxt = sel;
          dv_nxt  = 1'b1;
        end
      end
`ifdef DECODER_NX2N_SCAN_EN
      SCAN: begin
        dv_nxt = 1'b1;
        if (state != SCAN) begin
          d_nxt   = OUT_W'(1);
          idx_nxt = '0;
        end else if (tick) begin
          d_nxt    = {D[OUT_W-2:0], D[OUT_W-1]};
          idx_nxt  = idx + SEL_W'(1);
          wrap_nxt = (idx == '1);
        end
      end
`endif
      default: begin
        d_nxt   = '0;
        idx_nxt = '0;
        dv_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      D       <= '0;
      idx     <= '0;
      d_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      D       <= d_nxt;
      idx     <= idx_nxt;
      d_valid <= dv_nxt;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Self-checking bench for decoder_nx2n_seq: direct decode table, handshake,
// reset and (when DECODER_NX2N_SCAN_EN is defined) scan sequences.
module tb_decoder_nx2n_seq;

  logic        clk = 1'b0;
  logic        rst, en, mode, sel_valid;
  logic [2:0]  sel;
  logic [3:0]  sel4;
  logic        sel_ready, d_valid, wrap;
  logic [7:0]  d;
  logic [2:0]  idx;
  logic        sel_ready4, d_valid4, wrap4;
  logic [15:0] d4;
  logic [3:0]  idx4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_nx2n_seq #(.SEL_W(3), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .sel_ready(sel_ready), .D(d), .d_valid(d_valid),
    .idx(idx), .wrap(wrap)
  );

  decoder_nx2n_seq #(.SEL_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel4), .sel_ready(sel_ready4), .D(d4), .d_valid(d_valid4),
    .idx(idx4), .wrap(wrap4)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h01};
    vecs[1] = '{3'd1, 8'h02};
    vecs[2] = '{3'd2, 8'h04};
    vecs[3] = '{3'd3, 8'h08};
    vecs[4] = '{3'd4, 8'h10};
    vecs[5] = '{3'd5, 8'h20};
    vecs[6] = '{3'd6, 8'h40};
    vecs[7] = '{3'd7, 8'h80};

    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; sel4 = '0;
    cyc();
    cyc();
    check("rst_d", d, 0);
    check("rst_dv", d_valid, 0);
    check("rst_idx", idx, 0);
    check("rst_wrap", wrap, 0);
    check("rst_ready", sel_ready, 0);

    rst = 1'b0; en = 1'b1; mode = 1'b0;
    cyc();
    check("direct_ready", sel_ready, 1);
    check("dv_before_xfer", d_valid, 0);
    check("d_before_xfer", d, 0);

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      sel_valid = 1'b1;
      cyc();
      check("tbl_d", d, vecs[i].d);
      check("tbl_idx", idx, vecs[i].sel);
      check("tbl_dv", d_valid, 1);
    end

    sel_valid = 1'b0; sel = 3'd2;
    cyc();
    check("hold_d", d, 8'h80);
    check("hold_idx", idx, 7);

    sel = 3'd3; sel_valid = 1'b1; en = 1'b0;
    #1;
    check("ready_en_low", sel_ready, 0);
    cyc();
    check("en_low_d", d, 0);
    check("en_low_dv", d_valid, 0);
    cyc();
    check("en_low2_d", d, 0);
    en = 1'b1;
    cyc();
    check("reenter_d", d, 0);
    check("reenter_dv", d_valid, 0);
    cyc();
    check("reenter_xfer_d", d, 8'h08);
    check("reenter_xfer_idx", idx, 3);
    sel_valid = 1'b0;

`ifdef DECODER_NX2N_SCAN_EN
    begin
      int unsigned n;
      mode = 1'b1;
      cyc();
      check("scan_ready", sel_ready, 0);
      for (int unsigned c = 0; c < 30; c++) begin
        if (c > 0) cyc();
        check("scan_d", d, 64'd1 << ((c / 3) % 8));
        check("scan_wrap", wrap, (c == 24) ? 1 : 0);
      end

      n = 0;
      while (idx != 3'd5 && n < 100) begin
        cyc();
        n++;
      end
      check("wait_idx5", idx, 5);
      rst = 1'b1;
      #1;
      check("rst_ready_scan", sel_ready, 0);
      cyc();
      check("midscan_rst_d", d, 0);
      check("midscan_rst_idx", idx, 0);
      check("midscan_rst_wrap", wrap, 0);
      check("midscan_rst_dv", d_valid, 0);
      rst = 1'b0;
      cyc();
      check("scan_restart_d", d, 8'h01);
      check("scan_restart_idx", idx, 0);

      n = 0;
      while (idx != 3'd2 && n < 100) begin
        cyc();
        n++;
      end
      check("wait_idx2", idx, 2);
      mode = 1'b0; sel = 3'd6; sel_valid = 1'b1;
      cyc();
      check("switch_d", d, 0);
      check("switch_dv", d_valid, 0);
      cyc();
      check("switch_xfer_d", d, 8'h40);
      check("switch_xfer_idx", idx, 6);
      sel_valid = 1'b0;
    end
`else
    mode = 1'b1; sel = 3'd5; sel4 = 4'd9; sel_valid = 1'b1;
    cyc();
    check("noscan_d", d, 8'h20);
    check("noscan_d4", d4, 16'h0200);
    check("noscan_idx4", idx4, 9);
    check("noscan_dv4", d_valid4, 1);
    sel_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("noscan_wrap", wrap, 0);
      check("noscan_wrap4", wrap4, 0);
      check("noscan_hold_d4", d4, 16'h0200);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
